// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-ported, fixed-latency memory: an
// instruction-fetch read port (I) and a data read/write port (D), round-robin on ties.
module mem_arbiter #(
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic        owner_is_d_q, owner_is_d_d;
  logic        last_d_q, last_d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        busy_q, busy_d;

  // Next-state, grant and registered-output computation
  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    last_d_d     = last_d_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie D wins only if I was served last
        if (d_req && (!i_req || !last_d_q)) begin
          owner_is_d_d = 1'b1;
          last_d_d     = 1'b1;
          mem_en_d     = 1'b1;
          mem_wr_d     = d_wr;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          state_d      = ISSUE;
        end else if (i_req) begin
          owner_is_d_d = 1'b0;
          last_d_d     = 1'b0;
          mem_en_d     = 1'b1;
          mem_wr_d     = 1'b0;
          mem_addr_d   = i_addr;
          mem_wdata_d  = 16'h0000;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (mem_wr_q) begin
          d_done_d = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d   = 4'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          if (owner_is_d_q) begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_is_d_q <= 1'b0;
      last_d_q     <= 1'b0;
      cnt_q        <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      i_rdata_q    <= 16'h0000;
      d_rdata_q    <= 16'h0000;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      last_d_q     <= last_d_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-ported, fixed-latency main memory between two requesters: the instruction-fetch side (I, read-only) and the data side (D, read/write).
- Sits between the fetch/LW-SW pipeline stages (or their miss handlers) and the unified memory.
- Sequences each access as issue, latency wait, then response.
- Provides round-robin fairness when both sides request in the same cycle.

Parameters:
- MEM_LAT, 4, cycles from the memory-enable cycle to the cycle in which mem_rdata is valid; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  I-side read request; held high until i_done
- i_addr  in  16  I-side byte address
- i_rdata  out  16  I-side read data; valid when i_done=1, held until the next i_done
- i_done  out  1  one-cycle completion pulse to I-side
- d_req  in  1  D-side request; held high until d_done
- d_wr  in  1  D-side access type: 1 = write, 0 = read
- d_addr  in  16  D-side byte address
- d_wdata  in  16  D-side write data
- d_rdata  out  16  D-side read data; valid when d_done=1, held until the next d_done
- d_done  out  1  one-cycle completion pulse to D-side
- mem_en  out  1  memory enable; exactly one cycle per access
- mem_wr  out  1  memory write strobe; qualified by mem_en
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset and state encoding
  - Reset is synchronous, active-low; clk and rst_n are the only clock and reset.
  - States: IDLE, ISSUE, WAIT, RESP.
  - All state, counter, owner and output registers are registered.
  - Reset values: state=IDLE; mem_en=0, mem_wr=0; mem_addr=0, mem_wdata=0; i_rdata=0, d_rdata=0; i_done=0, d_done=0; last_d=0; busy=0.
- Arbitration (IDLE only)
  - Requests are sampled only in IDLE.
  - Only one request high: grant it.
  - Both high: grant D if last_d=0, otherwise grant I.
  - On grant: latch owner, address, write flag (forced to 0 for I) and write data into the mem_* output registers; set last_d = (owner==D); go to ISSUE.
  - No request: remain in IDLE.
- ISSUE (1 cycle)
  - mem_en=1; mem_wr=latched write flag.
  - Write: go to RESP.
  - Read: clear counter, go to WAIT.
- WAIT (MEM_LAT cycles)
  - mem_en=0; counter increments each cycle.
  - In the cycle counter==MEM_LAT-1, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle)
  - Owner's done=1; the other side's done stays 0; go to IDLE.
- Latency, with request first seen in IDLE cycle T
  - Read: mem_en in cycle T+1; done in cycle T+2+MEM_LAT.
  - Write: mem_en and mem_wr in cycle T+1; done in cycle T+2.
  - Back-to-back accesses have a minimum spacing of one IDLE cycle between the RESP of one and the sampling of the next.
- Output stability
  - mem_addr, mem_wdata and mem_wr hold the latched values from grant until the next grant.
  - Requester input changes during ISSUE, WAIT or RESP are ignored.
- rdata registers
  - Updated only on a read capture; write completions leave d_rdata unchanged.
  - The non-owner's rdata is never modified.
- Requester protocol
  - A requester deasserts req in the cycle after its done.
  - A req still high in the following IDLE is treated as a new request.
- Reset mid-operation
  - rst_n=0 in any state returns to IDLE next edge.
  - The in-flight access produces no done pulse; late memory data is discarded.
- Simultaneous events
  - A new request arriving during RESP is not granted until the IDLE cycle.
  - The non-granted side waits, and is guaranteed the next grant if it is still requesting.

Test Plan:
- Single I read, MEM_LAT=4, i_addr=0x0010, memory returns 0xBEEF: mem_en=1 only in T+1 with mem_addr=0x0010 and mem_wr=0; i_done=1 only in T+6 with i_rdata=0xBEEF; d_done never asserts.
- D write, d_addr=0x0100, d_wdata=0x1234: T+1 has mem_en=1, mem_wr=1, mem_addr=0x0100, mem_wdata=0x1234; d_done pulses in T+2; d_rdata is unchanged.
- Both request after reset (last_d=0): D is served first. I is granted in the IDLE after d_done, with i_done 6 cycles after that IDLE. Then both request again with last_d=1: I wins.
- Continuous contention, both req held high for 10 accesses: grants alternate D, I, D, I, and neither side waits more than one access.
- rst_n=0 during WAIT of an I read: no i_done; busy=0 and mem_en=0 after the reset edge. A following D read completes normally with the correct data.
- MEM_LAT=1: a D read of 0x00AA completes with d_done in T+3 and d_rdata=0x00AA.
